// File: rtl/angle_wrap_if.sv
// rtl/angle_wrap_if.sv - stream bundle between the angle producer, angle_wrap and the sin stage
// Producer drives the master side. angle_wrap sits on the slave side.
interface angle_wrap_if;
  logic        en;
  logic        in_valid;
  logic        cos_sel;
  logic [35:0] angle;
  logic        out_valid;
  logic        cos_sel_out;
  logic [35:0] angle_wrapped;
  logic [19:0] turns;

  modport master (
    output en,
    output in_valid,
    output cos_sel,
    output angle,
    input  out_valid,
    input  cos_sel_out,
    input  angle_wrapped,
    input  turns
  );

  modport slave (
    input  en,
    input  in_valid,
    input  cos_sel,
    input  angle,
    output out_valid,
    output cos_sel_out,
    output angle_wrapped,
    output turns
  );
endinterface

// File: rtl/angle_wrap.sv
// rtl/angle_wrap.sv - six-stage range reduction of a Q19.16 angle into [-pi, pi]
// An optional +pi/2 offset is applied first so the sin stage can produce cosine.
module angle_wrap (
  input  logic         clk,
  input  logic         rst,
  angle_wrap_if.slave  bus
);

  localparam int LATENCY = 6;

  localparam logic signed [35:0] HALF_PI    = 36'sd102944;
  localparam logic signed [35:0] PI         = 36'sd205887;
  localparam logic signed [35:0] TWO_PI     = 36'sd411775;
  localparam logic        [29:0] INV_TWO_PI = 30'd683565276;

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] cs_q, cs_d;

  logic signed [35:0] a0_s1_q, a0_s1_d;
  logic signed [71:0] p_s2_q, p_s2_d;
  logic signed [35:0] a0_s2_q, a0_s2_d;
  logic signed [19:0] k_s3_q, k_s3_d;
  logic signed [35:0] a0_s3_q, a0_s3_d;
  logic signed [35:0] m_s4_q, m_s4_d;
  logic signed [35:0] a0_s4_q, a0_s4_d;
  logic signed [19:0] k_s4_q, k_s4_d;
  logic signed [35:0] r_s5_q, r_s5_d;
  logic signed [19:0] k_s5_q, k_s5_d;
  logic signed [35:0] wrapped_q, wrapped_d;
  logic signed [19:0] turns_q, turns_d;

  // Only p[67:47] feeds the turn count; the remaining product bits are by-products.
  logic unused_p_bits;
  assign unused_p_bits = ^{p_s2_q[71:68], p_s2_q[46:0]};

  always_comb begin
    vld_d     = vld_q;
    cs_d      = cs_q;
    a0_s1_d   = a0_s1_q;
    p_s2_d    = p_s2_q;
    a0_s2_d   = a0_s2_q;
    k_s3_d    = k_s3_q;
    a0_s3_d   = a0_s3_q;
    m_s4_d    = m_s4_q;
    a0_s4_d   = a0_s4_q;
    k_s4_d    = k_s4_q;
    r_s5_d    = r_s5_q;
    k_s5_d    = k_s5_q;
    wrapped_d = wrapped_q;
    turns_d   = turns_q;

    if (bus.en) begin
      vld_d = {vld_q[LATENCY-2:0], bus.in_valid};
      cs_d  = {cs_q[LATENCY-2:0], bus.cos_sel};

      a0_s1_d = $signed(bus.angle) + (bus.cos_sel ? HALF_PI : 36'sd0);

      // Reciprocal is unsigned; the zero-extended operand keeps the multiply signed.
      p_s2_d  = $signed({{36{a0_s1_q[35]}}, a0_s1_q}) * $signed({42'd0, INV_TWO_PI});
      a0_s2_d = a0_s1_q;

      k_s3_d  = $signed(p_s2_q[67:48]) + $signed({19'd0, p_s2_q[47]});
      a0_s3_d = a0_s2_q;

      m_s4_d  = $signed({{16{k_s3_q[19]}}, k_s3_q}) * TWO_PI;
      a0_s4_d = a0_s3_q;
      k_s4_d  = k_s3_q;

      r_s5_d = a0_s4_q - m_s4_q;
      k_s5_d = k_s4_q;

      // Rounding error of the reciprocal leaves at most one turn to fix up.
      if (r_s5_q > PI) begin
        wrapped_d = r_s5_q - TWO_PI;
        turns_d   = k_s5_q + 20'sd1;
      end else if (r_s5_q < -PI) begin
        wrapped_d = r_s5_q + TWO_PI;
        turns_d   = k_s5_q - 20'sd1;
      end else begin
        wrapped_d = r_s5_q;
        turns_d   = k_s5_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      cs_q      <= '0;
      a0_s1_q   <= '0;
      p_s2_q    <= '0;
      a0_s2_q   <= '0;
      k_s3_q    <= '0;
      a0_s3_q   <= '0;
      m_s4_q    <= '0;
      a0_s4_q   <= '0;
      k_s4_q    <= '0;
      r_s5_q    <= '0;
      k_s5_q    <= '0;
      wrapped_q <= '0;
      turns_q   <= '0;
    end else begin
      vld_q     <= vld_d;
      cs_q      <= cs_d;
      a0_s1_q   <= a0_s1_d;
      p_s2_q    <= p_s2_d;
      a0_s2_q   <= a0_s2_d;
      k_s3_q    <= k_s3_d;
      a0_s3_q   <= a0_s3_d;
      m_s4_q    <= m_s4_d;
      a0_s4_q   <= a0_s4_d;
      k_s4_q    <= k_s4_d;
      r_s5_q    <= r_s5_d;
      k_s5_q    <= k_s5_d;
      wrapped_q <= wrapped_d;
      turns_q   <= turns_d;
    end
  end

  assign bus.out_valid     = vld_q[LATENCY-1];
  assign bus.cos_sel_out   = cs_q[LATENCY-1];
  assign bus.angle_wrapped = wrapped_q;
  assign bus.turns         = turns_q;

endmodule

// File: tb/tb_angle_wrap.sv
// tb/tb_angle_wrap.sv - self-checking bench for angle_wrap
// Reference: wide-integer arithmetic plus a queue of the last six enabled input slots.
module tb_angle_wrap;

  logic clk = 1'b0;
  logic rst = 1'b1;

  angle_wrap_if bus ();

  angle_wrap dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        v;
    logic        cs;
    logic [35:0] a;
  } ent_t;

  ent_t q[$];

  logic        exp_v;
  logic        exp_cs;
  logic [35:0] exp_w;
  logic [19:0] exp_t;
  longint      exp_a0;

  // k = round-half-up(a0 / 2pi) using the given reciprocal, then one correction.
  function automatic void ref_wrap(input logic cs, input logic [35:0] a,
                                   output logic [35:0] w, output logic [19:0] t,
                                   output longint a0_out);
    logic signed [127:0] a0, p, k, r;
    a0 = $signed({{92{a[35]}}, a});
    if (cs) a0 = a0 + 128'sd102944;
    p = a0 * 128'sd683565276;
    k = (p + 128'sh8000_0000_0000) >>> 48;
    r = a0 - k * 128'sd411775;
    if (r > 128'sd205887) begin
      r = r - 128'sd411775;
      k = k + 128'sd1;
    end else if (r < -128'sd205887) begin
      r = r + 128'sd411775;
      k = k - 128'sd1;
    end
    w      = r[35:0];
    t      = k[19:0];
    a0_out = longint'(a0[63:0]);
  endfunction

  function automatic logic [35:0] rand_angle();
    logic [63:0] r;
    logic [34:0] mag;
    logic [35:0] s;
    r   = {$urandom, $urandom};
    mag = r[34:0];
    if (r[40]) mag = {13'd0, mag[21:0]};
    if (mag > 35'h7_FFFE_0000) mag = mag - 35'h2_0000;
    s = {1'b0, mag};
    if (r[63]) s = -s;
    return s;
  endfunction

  task automatic tick(input logic e, input logic iv, input logic cs, input logic [35:0] a);
    ent_t ent;
    bus.en       = e;
    bus.in_valid = iv;
    bus.cos_sel  = cs;
    bus.angle    = a;
    @(posedge clk);
    if (e && !rst) begin
      ent.v  = iv;
      ent.cs = cs;
      ent.a  = a;
      q.push_back(ent);
      if (q.size() > 6) void'(q.pop_front());
    end
    #1;
    exp_v = 1'b0;
    if (q.size() == 6 && q[0].v) begin
      exp_v  = 1'b1;
      exp_cs = q[0].cs;
      ref_wrap(q[0].cs, q[0].a, exp_w, exp_t, exp_a0);
    end
  endtask

  task automatic test_reset;
    bus.en = 1'b0; bus.in_valid = 1'b0; bus.cos_sel = 1'b0; bus.angle = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    n_tests++;
    if (bus.cos_sel_out !== 1'b0) begin n_fail++; $display("FAIL reset_cos_sel_out got=%0b exp=0", bus.cos_sel_out); end
    n_tests++;
    if (bus.angle_wrapped !== 36'd0) begin n_fail++; $display("FAIL reset_angle_wrapped got=%0h exp=0", bus.angle_wrapped); end
    n_tests++;
    if (bus.turns !== 20'd0) begin n_fail++; $display("FAIL reset_turns got=%0h exp=0", bus.turns); end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_directed;
    logic [35:0] ang [7];
    logic        cs  [7];
    logic [35:0] ew  [7];
    logic [19:0] et  [7];
    ang[0] = 36'd0;        cs[0] = 1'b0; ew[0] = 36'd0;        et[0] = 20'd0;
    ang[1] = 36'd458752;   cs[1] = 1'b0; ew[1] = 36'd46977;    et[1] = 20'd1;
    ang[2] = -36'd655360;  cs[2] = 1'b0; ew[2] = 36'd168190;   et[2] = -20'd2;
    ang[3] = 36'd205887;   cs[3] = 1'b1; ew[3] = -36'd102944;  et[3] = 20'd1;
    ang[4] = 36'd205888;   cs[4] = 1'b0; ew[4] = -36'd205887;  et[4] = 20'd1;
    ang[5] = 36'd205887;   cs[5] = 1'b0; ew[5] = 36'd205887;   et[5] = 20'd0;
    ang[6] = 36'h4_0000_0000; cs[6] = 1'b0; ew[6] = 36'd204409; et[6] = 20'd41721;
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 1'b1, cs[i], ang[i]);
      repeat (4) tick(1'b1, 1'b0, 1'b0, '0);
      n_tests++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early_valid got=%0b exp=0", i, bus.out_valid); end
      tick(1'b1, 1'b0, 1'b0, '0);
      n_tests++;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_out_valid got=%0b exp=1", i, bus.out_valid); end
      n_tests++;
      if (bus.angle_wrapped !== ew[i]) begin n_fail++; $display("FAIL dir%0d_angle_wrapped got=%0d exp=%0d", i, $signed(bus.angle_wrapped), $signed(ew[i])); end
      n_tests++;
      if (bus.turns !== et[i]) begin n_fail++; $display("FAIL dir%0d_turns got=%0d exp=%0d", i, $signed(bus.turns), $signed(et[i])); end
      n_tests++;
      if (bus.cos_sel_out !== cs[i]) begin n_fail++; $display("FAIL dir%0d_cos_sel_out got=%0b exp=%0b", i, bus.cos_sel_out, cs[i]); end
      tick(1'b1, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic test_stall;
    logic [35:0] snap_w;
    logic [19:0] snap_t;
    logic        snap_v;
    int          seen;
    seen = 0;
    for (int i = 0; i < 22; i++) begin
      if (i >= 8 && i < 11) begin
        if (i == 8) begin
          snap_v = bus.out_valid; snap_w = bus.angle_wrapped; snap_t = bus.turns;
        end
        tick(1'b0, 1'b1, 1'b1, rand_angle());
        n_tests++;
        if (bus.out_valid !== snap_v || bus.angle_wrapped !== snap_w || bus.turns !== snap_t) begin
          n_fail++;
          $display("FAIL stall_frozen got=%0b/%0h/%0h exp=%0b/%0h/%0h", bus.out_valid, bus.angle_wrapped, bus.turns, snap_v, snap_w, snap_t);
        end
      end else if (i < 3 || (i >= 11 && i < 16)) begin
        tick(1'b1, 1'b1, i[0], rand_angle());
      end else begin
        tick(1'b1, (i < 8), 1'b0, rand_angle());
      end
      if (exp_v) begin
        if (bus.en) seen++;
        n_tests++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid got=%0b exp=1", bus.out_valid); end
        n_tests++;
        if (bus.angle_wrapped !== exp_w) begin n_fail++; $display("FAIL stall_angle_wrapped got=%0d exp=%0d", $signed(bus.angle_wrapped), $signed(exp_w)); end
        n_tests++;
        if (bus.turns !== exp_t) begin n_fail++; $display("FAIL stall_turns got=%0d exp=%0d", $signed(bus.turns), $signed(exp_t)); end
        n_tests++;
        if (bus.cos_sel_out !== exp_cs) begin n_fail++; $display("FAIL stall_cos_sel_out got=%0b exp=%0b", bus.cos_sel_out, exp_cs); end
      end else begin
        n_tests++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_bubble_valid got=%0b exp=0", bus.out_valid); end
      end
    end
    n_tests++;
    if (seen != 13) begin n_fail++; $display("FAIL stall_sample_count got=%0d exp=13", seen); end
  endtask

  task automatic test_reset_midflight;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, rand_angle());
    n_tests++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid got=%0b exp=1", bus.out_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.cos_sel_out !== 1'b0 || bus.angle_wrapped !== 36'd0 || bus.turns !== 20'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs got=%0b/%0b/%0h/%0h exp=0/0/0/0", bus.out_valid, bus.cos_sel_out, bus.angle_wrapped, bus.turns);
    end
    q.delete();
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, 1'b0, '0);
      n_tests++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_valid cycle=%0d got=%0b exp=0", i, bus.out_valid); end
    end
    tick(1'b1, 1'b1, 1'b1, 36'd0);
    for (int i = 1; i < 6; i++) begin
      n_tests++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_first_early edge=%0d got=%0b exp=0", i, bus.out_valid); end
      tick(1'b1, 1'b0, 1'b0, '0);
    end
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.angle_wrapped !== 36'd102944 || bus.turns !== 20'd0) begin
      n_fail++;
      $display("FAIL midrst_first_sample got=%0b/%0d/%0d exp=1/102944/0", bus.out_valid, $signed(bus.angle_wrapped), $signed(bus.turns));
    end
  endtask

  task automatic test_random;
    longint w, t;
    for (int i = 0; i < 10000; i++) begin
      tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1, rand_angle());
      if (exp_v) begin
        n_tests++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_out_valid i=%0d got=%0b exp=1", i, bus.out_valid); end
        n_tests++;
        if (bus.angle_wrapped !== exp_w) begin n_fail++; $display("FAIL rnd_angle_wrapped i=%0d got=%0d exp=%0d", i, $signed(bus.angle_wrapped), $signed(exp_w)); end
        n_tests++;
        if (bus.turns !== exp_t) begin n_fail++; $display("FAIL rnd_turns i=%0d got=%0d exp=%0d", i, $signed(bus.turns), $signed(exp_t)); end
        n_tests++;
        if (bus.cos_sel_out !== exp_cs) begin n_fail++; $display("FAIL rnd_cos_sel_out i=%0d got=%0b exp=%0b", i, bus.cos_sel_out, exp_cs); end
        w = longint'($signed(bus.angle_wrapped));
        t = longint'($signed(bus.turns));
        n_tests++;
        if (w > 205887 || w < -205887) begin n_fail++; $display("FAIL rnd_range i=%0d got=%0d exp=|x|<=205887", i, w); end
        n_tests++;
        if (w + t * 411775 != exp_a0) begin n_fail++; $display("FAIL rnd_identity i=%0d got=%0d exp=%0d", i, w + t * 411775, exp_a0); end
      end else begin
        n_tests++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_bubble_valid i=%0d got=%0b exp=0", i, bus.out_valid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/angle_wrap.md
# angle_wrap

Range-reduction stage placed directly upstream of the `sin` pipeline. The `sin` parabolic approximation is only valid for inputs in [-π, π]. This block takes an arbitrary signed Q19.16 angle, optionally adds π/2 so the same `sin` instance can produce cosine, and wraps the result into [-π, π]. It also returns the integer number of removed turns. It is fully pipelined with a fixed latency, accepts one angle per enabled cycle, and uses the same `clk`/`en` stall semantics as its consumer.

## Interface
- `LATENCY`, 6: enabled cycles from input capture to output; fixed, not meant to be overridden.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  pipeline advance (clock enable); when 0 every register, including valid bits, holds.
- `in_valid`  in  1  `angle`/`cos_sel` are meaningful this cycle.
- `cos_sel`  in  1  1: add π/2 before wrapping (cosine request); 0: plain wrap.
- `angle`  in  36  signed two's-complement Q19.16, 16 fractional bits, radians.
- `out_valid`  out  1  outputs are meaningful.
- `cos_sel_out`  out  1  `cos_sel` delayed alongside its angle.
- `angle_wrapped`  out  36  signed Q19.16 result in [-205887, +205887] raw, which is [-π, π].
- `turns`  out  20  signed integer k such that the pre-wrap angle equals `angle_wrapped` + k·2π (raw 411775).

## Operation
- Constants (Q16 raw):
  - π/2 = 102944
  - π = 205887
  - 2π = 411775
  - 1/(2π) scaled by 2^32 = 683565276 (30-bit unsigned)
- Pipeline stages. Each register loads only when `en`=1.
  - S1: `a0 = angle + (cos_sel ? 102944 : 0)`, 36-bit wrapping add. Valid input range is |`angle`| ≤ 2^35 − 2^17 raw; results outside this range are unspecified.
  - S2: `p = a0 × 683565276`, signed × unsigned, 72-bit product. `a0` is delayed alongside it.
  - S3: `k = p[67:48] + p[47]`, round-half-up to the nearest integer turn, 20-bit signed.
  - S4: `m = k × 411775`, keeping the low 36 bits (never overflows in range). `a0` and `k` are delayed alongside it.
  - S5: `r = a0 − m`, 36-bit.
  - S6, single correction:
    - if `r` > 205887: `angle_wrapped = r − 411775`, `turns = k + 1`.
    - else if `r` < −205887: `angle_wrapped = r + 411775`, `turns = k − 1`.
    - else: `angle_wrapped = r`, `turns = k`.
- Coefficient error is below 1e-9 relative, so `|r|` never exceeds π + 2π. One correction step is therefore always sufficient.
- `in_valid` and `cos_sel` travel through a 6-deep shift register in lockstep with the data. Data registers load regardless of valid; only `out_valid` qualifies the outputs.
- No backpressure beyond `en`. The downstream `sin` shares `en`, so nothing is dropped or duplicated.

## Timing
- Latency: a sample presented on enabled cycle N appears on outputs after the 6th enabled rising edge counting from N.
- Throughput: one sample per enabled cycle; back-to-back samples are independent.
- `en`=0 for any number of cycles freezes all outputs and in-flight samples. On resume, the sequence continues with no loss.
- Reset (async, takes effect immediately, mid-operation included): all valid bits clear. `out_valid`=0, `cos_sel_out`=0, `angle_wrapped`=0, `turns`=0, and all data registers are cleared. The first `out_valid` after deassertion occurs 6 enabled edges after the first accepted `in_valid`.
- `in_valid`=0 bubbles propagate as `out_valid`=0 in the matching slot.

## Test plan
- Zero: `angle`=0, `cos_sel`=0 → 6 cycles later `out_valid`=1, `angle_wrapped`=0, `turns`=0.
- Plain wrap: `angle`=458752 (7.0 rad) → `angle_wrapped`=46977, `turns`=1. `angle`=−655360 (−10 rad) → `angle_wrapped`=168190, `turns`=−2.
- Cosine offset: `angle`=205887 (π), `cos_sel`=1 → `angle_wrapped`=−102944, `turns`=1, `cos_sel_out`=1.
- Boundary and large input:
  - `angle`=205888 → `angle_wrapped`=−205887, `turns`=1.
  - `angle`=205887 → unchanged, `turns`=0.
  - `angle`=2^34 → `angle_wrapped`=204409, `turns`=41721.
- Stall and reset:
  - Stream 8 back-to-back samples, drop `en` for 3 cycles mid-stream → identical output order and values, `out_valid` frozen during the stall.
  - Assert `rst` with 4 samples in flight → outputs go to 0 immediately, and no stale `out_valid` appears afterward.
- Random compare: 10k random in-range angles, both `cos_sel` values, random `en` → match a bit-exact reference model. Additionally check |`angle_wrapped`| ≤ 205887 and that `angle_wrapped` + `turns`·411775 equals the pre-wrap angle exactly.
